bcd4_counter_scan: RTL

Four-digit BCD up/down counter with a built-in display scan generator. It is the stage directly upstream of the 16-to-4 nibble multiplexer in the display path: `dat` carries the packed BCD value, and `adr` is the rotating digit select that picks one nibble for the 7-segment decoder. `an` drives the matching common-anode enable. The count advances on a prescaled tick, so one block serves both slow human-visible counting and fast digit refresh.

---
 rtl/bcd4_counter_scan_pkg.sv | 24 ++
 rtl/bcd4_counter_scan_digit.sv | 61 ++++++
 rtl/bcd4_counter_scan.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bcd4_counter_scan_pkg.sv
// ---------------------------------------------------------------------------
// bcd4_counter_scan_pkg
// Shared constants and helpers for the four-digit BCD counter with display
// scan generator.
//   BCD_DIGITS : number of decades in the counter
//   BCD_MAX    : largest legal BCD digit value
//   AN_RESET   : common-anode enable pattern selecting digit 0 (active-low)
//   bcd_digit_t: one packed BCD nibble
//   bcd_clamp  : saturates an out-of-range nibble to 9
// ---------------------------------------------------------------------------
package bcd4_counter_scan_pkg;

  localparam int         BCD_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] AN_RESET   = 4'b1110;

  typedef logic [3:0] bcd_digit_t;

  // Loaded nibbles above 9 are not valid BCD; store them as 9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd4_counter_scan_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One BCD decade with clear, load and carry/borrow chaining.
//   clk, rst_n : clock and asynchronous active-low reset
//   ci         : step request from the lower decade (or the count tick)
//   up         : 1 = increment, 0 = decrement
//   ld, ld_val : synchronous load of a nibble (clamped to 9)
//   clr        : synchronous clear, wins over ld and ci
//   q          : registered digit value
//   co         : combinational carry/borrow into the next decade
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd4_counter_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ci,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       clr,
  output logic [3:0] q,
  output logic       co
);

  bcd_digit_t q_reg;
  bcd_digit_t q_next;

  // The next decade steps only when this one rolls over in the current
  // direction; clr/load suppression of the rollover is handled by q_next
  // priority here and by carry gating in the top.
  always_comb begin
    co = ci & (up ? (q_reg == BCD_MAX) : (q_reg == 4'd0));
  end

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = 4'd0;
    end else if (ld) begin
      q_next = bcd_clamp(ld_val);
    end else if (ci) begin
      if (up) begin
        q_next = (q_reg == BCD_MAX) ? 4'd0 : q_reg + 4'd1;
      end else begin
        q_next = (q_reg == 4'd0) ? BCD_MAX : q_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 4'd0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/bcd4_counter_scan.sv
// ---------------------------------------------------------------------------
// bcd4_counter_scan
// Four-digit BCD up/down counter advancing on a prescaled tick, plus a
// free-running digit scan generator for a multiplexed 7-segment display.
//   PRESCALE : clock cycles per count tick (>=1)
//   SCAN_DIV : clock cycles per digit-select step (>=1)
//   clk, rst_n         : clock and asynchronous active-low reset
//   en, up             : count enable (sampled on ticks) and direction
//   clr, load, load_val: synchronous clear / load (clr wins)
//   dat   : registered packed BCD count, digit 0 in [3:0]
//   adr   : registered digit select
//   an    : registered active-low digit enable, always ~(1<<adr)
//   tick  : one-cycle pulse on the last prescaler cycle
//   carry : one-cycle pulse when the count wraps in either direction
// ---------------------------------------------------------------------------
module bcd4_counter_scan
  import bcd4_counter_scan_pkg::*;
#(
  parameter int PRESCALE = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] dat,
  output logic [1:0]  adr,
  output logic [3:0]  an,
  output logic        tick,
  output logic        carry
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SCAN_DIV - 1);

  // ---------------- prescaler ----------------
  logic [PW-1:0] pcnt_reg, pcnt_next;
  logic          tick_reg, tick_next;

  always_comb begin
    pcnt_next = pcnt_reg + 1'b1;
    if (clr || load || (pcnt_reg == PCNT_LAST)) begin
      pcnt_next = '0;
    end
  end

  // tick is registered from the look-ahead count so it is a clean flop
  // output that still sits high exactly while pcnt holds PRESCALE-1.
  assign tick_next = (pcnt_next == PCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_next;
      tick_reg <= tick_next;
    end
  end

  // ---------------- BCD decade chain ----------------
  logic [BCD_DIGITS:0] ci;
  logic                carry_reg, carry_next;

  assign ci[0] = tick_reg & en;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk    (clk),
        .rst_n  (rst_n),
        .ci     (ci[gi]),
        .up     (up),
        .ld     (load),
        .ld_val (load_val[gi*4 +: 4]),
        .clr    (clr),
        .q      (dat[gi*4 +: 4]),
        .co     (ci[gi+1])
      );
    end
  endgenerate

  // A rollover out of the top decade is a wrap, unless clr/load overrides
  // the count in the same cycle.
  assign carry_next = ci[BCD_DIGITS] & ~clr & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
    end else begin
      carry_reg <= carry_next;
    end
  end

  // ---------------- display scan ----------------
  logic [SW-1:0] scnt_reg, scnt_next;
  logic [1:0]    adr_reg, adr_next;
  logic [3:0]    an_reg, an_next;

  always_comb begin
    scnt_next = scnt_reg + 1'b1;
    adr_next  = adr_reg;
    if (scnt_reg == SCNT_LAST) begin
      scnt_next = '0;
      adr_next  = adr_reg + 2'd1;
    end
  end

  // Derived from adr_next so adr and an always update on the same edge.
  assign an_next = ~(4'b0001 << adr_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_reg <= '0;
      adr_reg  <= 2'd0;
      an_reg   <= AN_RESET;
    end else begin
      scnt_reg <= scnt_next;
      adr_reg  <= adr_next;
      an_reg   <= an_next;
    end
  end

  assign adr   = adr_reg;
  assign an    = an_reg;
  assign tick  = tick_reg;
  assign carry = carry_reg;

endmodule
